// File: rtl/data_generator_if.sv
// Packet stream between the data generator and a PE.
//   out_data  : packet payload, driven by the master, zero while out_valid is low
//   out_valid : master has a packet on out_data
//   out_ready : slave accepts the packet when out_valid and out_ready are both high
interface data_generator_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/data_generator.sv
// Packet source that feeds one PE with a filter packet followed by NUM_ROWS ifmap rows.
//   clk, rst_n : clock and asynchronous active-low reset
//   filter_in  : five 8-bit filter weights, latched when a run starts
//   row_wr/row_addr/row_data : ifmap row store write port (idle only)
//   start      : one-cycle pulse that begins a run (ignored while busy)
//   out_if     : valid/ready packet stream to the PE
//   busy       : a run is in progress
//   done       : one-cycle pulse after the last packet of a run is accepted
//   pkt_count  : packets accepted since reset, wrapping
module data_generator #(
  parameter int unsigned WIDTH     = 64,
  parameter logic [3:0]  SRC_ADDR  = 4'b1111,
  parameter logic [3:0]  DEST_ADDR = 4'b0000,
  parameter int unsigned NUM_ROWS  = 5,
  parameter int unsigned GAP       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [39:0]            filter_in,
  input  logic                   row_wr,
  input  logic [2:0]             row_addr,
  input  logic [24:0]            row_data,
  input  logic                   start,
  data_generator_if.master       out_if,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             pkt_count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StFilt = 3'd1;
  localparam logic [2:0] StRows = 3'd2;
  localparam logic [2:0] StGapw = 3'd3;
  localparam logic [2:0] StFin  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [39:0]      filter_q, filter_d;
  logic [7:0]       pkt_count_q, pkt_count_d;
  // Always eight entries; those at or above NUM_ROWS are never written and stay zero.
  logic [24:0]      rows_q [8];
  logic [24:0]      rows_d [8];

  logic             accept;
  logic             last_row;
  logic [2:0]       nxt_idx;
  logic [WIDTH-1:0] nxt_pkt;

  function automatic logic [WIDTH-1:0] filt_pkt(input logic [39:0] f);
    return WIDTH'({SRC_ADDR, DEST_ADDR, 2'b01, 14'b0, f});
  endfunction

  function automatic logic [WIDTH-1:0] row_pkt(input logic [24:0] r);
    return WIDTH'({SRC_ADDR, DEST_ADDR, 2'b00, 29'b0, r});
  endfunction

  assign accept   = valid_q & out_if.out_ready;
  assign last_row = (row_idx_q == 3'(NUM_ROWS - 1));
  // Row that follows the packet now on the bus: row 0 after the filter, else the next index.
  assign nxt_idx  = (state_q == StFilt) ? 3'd0 : row_idx_q + 3'd1;
  assign nxt_pkt  = row_pkt(rows_q[nxt_idx]);

  // Row store: writes only while idle and only to rows that a run will send.
  always_comb begin
    rows_d = rows_q;
    if (row_wr && (state_q == StIdle) && ({1'b0, row_addr} < 4'(NUM_ROWS))) begin
      rows_d[row_addr] = row_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    data_d      = data_q;
    row_idx_d   = row_idx_q;
    gap_cnt_d   = gap_cnt_q;
    filter_d    = filter_q;
    pkt_count_d = accept ? pkt_count_q + 8'd1 : pkt_count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFilt;
          filter_d  = filter_in;
          row_idx_d = 3'd0;
        end
      end
      StFilt, StRows: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = (state_q == StFilt) ? filt_pkt(filter_q) : row_pkt(rows_q[row_idx_q]);
        end else if (accept) begin
          if ((state_q == StRows) && last_row) begin
            state_d = StFin;
            valid_d = 1'b0;
            data_d  = '0;
          end else begin
            row_idx_d = nxt_idx;
            if (GAP == 0) begin
              // Back-to-back: next packet goes on the bus in the same edge.
              state_d = StRows;
              valid_d = 1'b1;
              data_d  = nxt_pkt;
            end else begin
              state_d   = StGapw;
              valid_d   = 1'b0;
              data_d    = '0;
              gap_cnt_d = 4'd0;
            end
          end
        end
      end
      StGapw: begin
        // Present the pending row on the last gap cycle so valid is low exactly GAP cycles.
        if (gap_cnt_q == 4'(GAP - 1)) begin
          state_d = StRows;
          valid_d = 1'b1;
          data_d  = row_pkt(rows_q[row_idx_q]);
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      data_q      <= '0;
      row_idx_q   <= 3'd0;
      gap_cnt_q   <= 4'd0;
      filter_q    <= '0;
      pkt_count_q <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      row_idx_q   <= row_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      filter_q    <= filter_d;
      pkt_count_q <= pkt_count_d;
      for (int i = 0; i < 8; i++) begin
        rows_q[i] <= rows_d[i];
      end
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StFin);
  assign pkt_count        = pkt_count_q;

endmodule

// File: tb/tb_data_generator.sv
module tb_data_generator;

  localparam int NR = 5;

  logic        clk;
  logic        rst_n;
  logic [39:0] filter_in;
  logic        row_wr;
  logic [2:0]  row_addr;
  logic [24:0] row_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  pkt_count;

  data_generator_if #(.WIDTH(64)) bus ();

  data_generator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .filter_in (filter_in),
    .row_wr    (row_wr),
    .row_addr  (row_addr),
    .row_data  (row_data),
    .start     (start),
    .out_if    (bus),
    .busy      (busy),
    .done      (done),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: packet layout from the field rules, run = filter then rows in order.
  function automatic logic [63:0] pkt_filter(input logic [39:0] f);
    return {4'hF, 4'h0, 2'b01, 14'b0, f};
  endfunction

  function automatic logic [63:0] pkt_row(input logic [24:0] r);
    return {4'hF, 4'h0, 2'b00, 29'b0, r};
  endfunction

  logic [24:0] rows_m [8];
  logic [63:0] q [$];
  logic [63:0] acc_log [$];
  bit          m_busy;
  bit          first;
  bit          exp_done;
  bit          last_done;
  bit          exp_valid;
  int          m_cnt;
  int          run_acc;
  int          vrun;
  int          vrun_max;

  // Monitor: samples on the falling edge, compares against the model, then
  // advances the model for the inputs that the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_cnt", 64'(pkt_count), 64'd0);
      q.delete();
      m_busy   = 0;
      first    = 0;
      exp_done = 0;
      m_cnt    = 0;
      run_acc  = 0;
      vrun     = 0;
      for (int i = 0; i < 8; i++) rows_m[i] = '0;
    end else begin
      exp_valid = (q.size() > 0) && !first;
      first = 0;
      check_eq("valid", 64'(bus.out_valid), 64'(exp_valid));
      check_eq("data", bus.out_data, exp_valid ? q[0] : 64'd0);
      check_eq("busy", 64'(busy), 64'(m_busy));
      check_eq("done", 64'(done), 64'(exp_done));
      check_eq("pkt_count", 64'(pkt_count), 64'(m_cnt % 256));
      if (bus.out_valid) begin
        vrun++;
        if (vrun > vrun_max) vrun_max = vrun;
      end else begin
        vrun = 0;
      end
      last_done = exp_done;
      exp_done  = 0;
      if (exp_valid && bus.out_ready) begin
        acc_log.push_back(q[0]);
        void'(q.pop_front());
        m_cnt++;
        run_acc++;
        if (q.size() == 0) exp_done = 1;
      end
      if (row_wr && !m_busy && (row_addr < NR)) rows_m[row_addr] = row_data;
      if (start && !m_busy) begin
        m_busy  = 1;
        first   = 1;
        run_acc = 0;
        q.push_back(pkt_filter(filter_in));
        for (int i = 0; i < NR; i++) q.push_back(pkt_row(rows_m[i]));
      end
      if (last_done) m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] a, input logic [24:0] d);
    row_wr = 1; row_addr = a; row_data = d;
    tick();
    row_wr = 0;
  endtask

  task automatic do_start(input logic [39:0] f);
    filter_in = f; start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input int budget, input bit noisy);
    int n = 0;
    while (m_busy && n < budget) begin
      if (noisy) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        row_wr    = ($urandom_range(0, 1) == 1);
        row_addr  = 3'($urandom());
        row_data  = 25'($urandom());
        start     = ($urandom_range(0, 7) == 0);
        filter_in = 40'({$urandom(), $urandom()});
      end
      tick();
      n++;
    end
    row_wr = 0; start = 0; bus.out_ready = 1;
    check_eq("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic wait_acc(input int cnt, input int budget);
    int n = 0;
    while (run_acc < cnt && n < budget) begin
      tick();
      n++;
    end
    check_eq("acc_timeout", 64'(run_acc >= cnt), 64'd1);
  endtask

  initial begin
    rst_n = 0; start = 0; row_wr = 0; row_addr = 0; row_data = 0; filter_in = 0;
    bus.out_ready = 1;
    vrun_max = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();

    // Basic run with known filter and row 0, plus ignored out-of-range writes.
    write_row(3'd0, 25'h1FFFFFF);
    for (int i = 1; i < NR; i++) write_row(3'(i), 25'($urandom()));
    write_row(3'd5, 25'h1234567);
    write_row(3'd7, 25'h0ABCDEF);
    acc_log.delete(); vrun_max = 0;
    do_start(40'h01_0203_0405);
    wait_idle(100, 0);
    check_eq("filter_pkt", acc_log.size() > 0 ? acc_log[0] : 64'd0, 64'hF040_0001_0203_0405);
    check_eq("row0_pkt", acc_log.size() > 1 ? acc_log[1] : 64'd0, 64'hF000_0000_01FF_FFFF);
    check_eq("run_len", 64'(acc_log.size()), 64'd6);
    check_eq("valid_burst", 64'(vrun_max), 64'd6);
    check_eq("pkt_count6", 64'(pkt_count), 64'd6);

    // Backpressure for 10 cycles while row 2 is presented.
    acc_log.delete();
    do_start(40'({$urandom(), $urandom()}));
    wait_acc(3, 50);
    bus.out_ready = 0;
    repeat (10) tick();
    bus.out_ready = 1;
    wait_idle(100, 0);
    check_eq("bp_run_len", 64'(acc_log.size()), 64'd6);
    check_eq("bp_row3", acc_log.size() > 4 ? acc_log[4] : 64'd0, pkt_row(rows_m[3]));

    // Start and row write while busy must both be ignored.
    acc_log.delete();
    do_start(40'h55_5555_5555);
    tick();
    start = 1; filter_in = 40'hFF_FFFF_FFFF;
    row_wr = 1; row_addr = 3'd0; row_data = 25'h0AAAAAA;
    tick();
    start = 0; row_wr = 0;
    wait_idle(100, 0);
    check_eq("ill_run_len", 64'(acc_log.size()), 64'd6);
    acc_log.delete();
    do_start(40'h11_2233_4455);
    wait_idle(100, 0);
    check_eq("row0_kept", acc_log.size() > 1 ? acc_log[1] : 64'd0, 64'hF000_0000_01FF_FFFF);

    // Random runs: random writes, random backpressure, noise while busy; wraps pkt_count.
    for (int r = 0; r < 45; r++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        write_row(3'($urandom()), 25'($urandom()));
      end
      do_start(40'({$urandom(), $urandom()}));
      wait_idle(300, 1);
      tick();
    end
    check_eq("wrapped", 64'(m_cnt > 256), 64'd1);

    // Reset in the middle of a run, then a fresh run with cleared rows.
    bus.out_ready = 1;
    do_start(40'({$urandom(), $urandom()}));
    wait_acc(2, 50);
    rst_n = 0;
    #1;
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_cnt", 64'(pkt_count), 64'd0);
    check_eq("mid_rst_data", bus.out_data, 64'd0);
    repeat (2) tick();
    rst_n = 1;
    repeat (4) tick();
    acc_log.delete();
    do_start(40'h01_0203_0405);
    wait_idle(100, 0);
    check_eq("post_rst_filter", acc_log.size() > 0 ? acc_log[0] : 64'd0, 64'hF040_0001_0203_0405);
    check_eq("post_rst_row0", acc_log.size() > 1 ? acc_log[1] : 64'd0, 64'hF000_0000_0000_0000);
    check_eq("post_rst_row4", acc_log.size() > 5 ? acc_log[5] : 64'd1, 64'hF000_0000_0000_0000);
    check_eq("post_rst_cnt", 64'(pkt_count), 64'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_generator.md
DATA_GENERATOR -- requirements
Module: data_generator

Interface
REQ-001 Parameter WIDTH, 64, packet width in bits.
REQ-002 Parameter SRC_ADDR, 4'b1111, source address placed in packet bits [63:60].
REQ-003 Parameter DEST_ADDR, 4'b0000, destination PE address placed in packet bits [59:56].
REQ-004 Parameter NUM_ROWS, 5, number of ifmap rows stored and sent per run (1..8).
REQ-005 Parameter GAP, 0, idle cycles inserted after each accepted packet (0..15).
REQ-006 Port clk, input, 1, single clock, all state on rising edge.
REQ-007 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 Port filter_in, input, 40, five 8-bit filter weights, byte 0 in [7:0].
REQ-009 Port row_wr, input, 1, write strobe for the ifmap row store.
REQ-010 Port row_addr, input, 3, row index to write.
REQ-011 Port row_data, input, 25, one binary ifmap row (spike bits).
REQ-012 Port start, input, 1, single-cycle pulse that begins a run.
REQ-013 Port out_data, output, 64, packet to the PE.
REQ-014 Port out_valid, output, 1, out_data is valid.
REQ-015 Port out_ready, input, 1, consumer accepts a packet when out_valid and out_ready are both high.
REQ-016 Port busy, output, 1, high from the start acceptance until the run ends.
REQ-017 Port done, output, 1, one-cycle pulse after the last packet of a run is accepted.
REQ-018 Port pkt_count, output, 8, number of packets accepted since reset, wrapping 255->0.

Function
REQ-019 Packet field layout SHALL be [63:60] SRC_ADDR, [59:56] DEST_ADDR, [55:54] type (00 ifmap, 01 filter, 10 psum, 11 reserved), and payload in the low bits with unused bits 0.
REQ-020 A filter packet SHALL be {SRC_ADDR, DEST_ADDR, 2'b01, 14'b0, filter}, where filter is the value of filter_in latched in the cycle start is accepted.
REQ-021 An ifmap packet SHALL be {SRC_ADDR, DEST_ADDR, 2'b00, 29'b0, row}.
REQ-022 The FSM SHALL have the states IDLE, FILT, ROWS, GAPW and FIN.
REQ-023 FSM transitions: IDLE + start -> FILT; FILT accepted -> GAPW (or ROWS when GAP=0); ROWS accepted with index < NUM_ROWS-1 -> index++ and then GAPW/ROWS; last row accepted -> FIN; FIN -> IDLE after one cycle with done high.
REQ-024 A run SHALL send exactly one filter packet followed by rows 0..NUM_ROWS-1 in ascending order.
REQ-025 out_valid SHALL assert in the cycle after entry to FILT or ROWS.
REQ-026 While out_valid is high and out_ready is low, out_data and out_valid SHALL remain stable.
REQ-027 out_valid SHALL drop in the cycle after acceptance unless the next packet follows with GAP=0, giving back-to-back throughput of 1 packet/cycle.
REQ-028 GAPW SHALL hold out_valid low for exactly GAP cycles.
REQ-029 out_data SHALL be 0 whenever out_valid is low.
REQ-030 A start pulse while busy SHALL be ignored.
REQ-031 row_wr SHALL write the row store only when busy is low.
REQ-032 row_wr while busy, and any row_addr >= NUM_ROWS, SHALL be ignored.
REQ-033 pkt_count SHALL increment by 1 per accepted packet.
REQ-034 pkt_count SHALL wrap from 255 to 0.
REQ-035 busy SHALL be high in FILT, ROWS, GAPW and FIN.

Reset
REQ-036 On rst_n low the block SHALL immediately clear out_valid, out_data, busy, done, pkt_count, the row index, the latched filter and every row entry to 0, and force the FSM to IDLE, including mid-run.
REQ-037 After rst_n is released, a new start SHALL be required, with no partial resumption.

Verification
REQ-038 Filter packet: filter_in=40'h0102030405, start, out_ready=1 -> first packet 64'hF040_0001_0203_0405.
REQ-039 Ifmap packet: row0=25'h1FFFFFF -> second packet 64'hF000_0000_01FF_FFFF.
REQ-040 Run length: NUM_ROWS=5, GAP=0, out_ready=1 -> 6 consecutive valid cycles, then a done pulse, and pkt_count=6.
REQ-041 Backpressure: out_ready=0 for 10 cycles during row 2 -> out_data is stable, row 3 is not skipped, and the order is preserved.
REQ-042 Illegal writes: start while busy, and row_wr during a run -> no second run and stored rows unchanged, verified on the next run.
REQ-043 Mid-run reset: rst_n low during row 1 -> out_valid=0 and pkt_count=0 at once, and a fresh start sends the filter packet with all-zero rows.
